// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_pkg
//  Purpose  : Shared sizing helpers for the FIFO read-side streamer.
//  Revision : 1.0
// ============================================================================
package fifo_rd_pkg;

    localparam int c_rd_latency_min = 1;
    localparam int c_rd_latency_max = 3;

    // Out-of-range latencies are clamped so the buffer is never undersized.
    function automatic int skid_depth(input int rd_latency);
        int lat;
        lat = rd_latency;
        if (lat < c_rd_latency_min) lat = c_rd_latency_min;
        if (lat > c_rd_latency_max) lat = c_rd_latency_max;
        return lat + 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_streamer_if
//  Purpose  : FIFO read port plus valid/ready output stream.
//  Revision : 1.0
// ============================================================================
interface fifo_rd_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output rd_en,
        input  rd_data,
        input  empty,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output empty,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_skid_buf
//  Purpose  : Circular buffer absorbing words that land after the credit stop.
//  Revision : 1.0
// ============================================================================
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         push,
    input  wire logic [DATA_WIDTH-1:0]        push_data,
    input  wire logic                         pop,
    output logic      [occ_width(DEPTH)-1:0]  occ,
    output logic      [DATA_WIDTH-1:0]        head_data
);
    localparam int c_ptr_w = ptr_width(DEPTH);
    localparam int c_occ_w = occ_width(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic [c_occ_w-1:0]    r_occ;

    // Memory is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= (r_tail == c_ptr_last) ? '0 : r_tail + c_ptr_w'(1);
            end
            if (pop) begin
                r_head <= (r_head == c_ptr_last) ? '0 : r_head + c_ptr_w'(1);
            end
            if (push && !pop)      r_occ <= r_occ + c_occ_w'(1);
            else if (pop && !push) r_occ <= r_occ - c_occ_w'(1);
        end
    end

    assign occ       = r_occ;
    assign head_data = r_mem[r_head];
endmodule
`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_streamer
//  Purpose  : Credit-managed FIFO reader presenting a full-rate valid/ready stream.
//  Revision : 1.0
// ============================================================================
module fifo_rd_streamer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  wire logic                 rd_clk,
    input  wire logic                 rd_rst,
    fifo_rd_streamer_if.master        bus,
    output logic      [CNT_WIDTH-1:0] word_cnt,
    output logic                      underflow
);
    localparam int c_depth = skid_depth(RD_LATENCY);
    localparam int c_occ_w = occ_width(c_depth);
    localparam int c_sum_w = c_occ_w + 1;

    logic [RD_LATENCY-1:0] r_inflight;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  r_underflow;
    logic [c_occ_w-1:0]    w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic [c_sum_w-1:0]    w_used;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_en;

    // A slot freed by this cycle's pop is immediately reusable, which keeps
    // rd_en high every cycle in steady state.
    always_comb begin
        w_pop   = bus.m_valid & bus.m_ready;
        w_used  = c_sum_w'(w_occ) + c_sum_w'($countones(r_inflight));
        w_rd_en = !rd_rst && !bus.empty
                  && ((w_used - c_sum_w'(w_pop)) < c_sum_w'(c_depth));
    end

    assign w_push = r_inflight[RD_LATENCY-1];

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_inflight  <= '0;
            r_word_cnt  <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_inflight  <= RD_LATENCY'({r_inflight, w_rd_en});
            r_word_cnt  <= r_word_cnt + CNT_WIDTH'(w_pop);
            r_underflow <= r_underflow | (w_rd_en & bus.empty);
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (c_depth)
    ) u_skid (
        .clk        (rd_clk),
        .rst        (rd_rst),
        .push       (w_push),
        .push_data  (bus.rd_data),
        .pop        (w_pop),
        .occ        (w_occ),
        .head_data  (w_head)
    );

    assign bus.rd_en   = w_rd_en;
    assign bus.m_valid = (w_occ != '0);
    assign bus.m_data  = w_head;
    assign word_cnt    = r_word_cnt;
    assign underflow   = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_streamer
//  Purpose  : Three streamers (latency 1/2/3) against a queue-based FIFO model.
//  Revision : 1.0
// ============================================================================
module tb_fifo_rd_streamer;
    localparam int NL     = 3;
    localparam int N_RAND = 1000;

    typedef struct {
        bit         ready;
        bit         exp_rd_en;
        bit         exp_valid;
        bit         chk_data;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a   [NL];
    logic       empty_a [NL];
    logic       ready_a [NL];
    logic [7:0] rdd_a   [NL];
    logic [31:0] wc0, wc1;
    logic [3:0]  wc2;
    logic        uf [NL];

    fifo_rd_streamer_if #(.DATA_WIDTH(8)) bus0 ();
    fifo_rd_streamer_if #(.DATA_WIDTH(8)) bus1 ();
    fifo_rd_streamer_if #(.DATA_WIDTH(8)) bus2 ();

    assign bus0.empty = empty_a[0]; assign bus0.m_ready = ready_a[0]; assign bus0.rd_data = rdd_a[0];
    assign bus1.empty = empty_a[1]; assign bus1.m_ready = ready_a[1]; assign bus1.rd_data = rdd_a[1];
    assign bus2.empty = empty_a[2]; assign bus2.m_ready = ready_a[2]; assign bus2.rd_data = rdd_a[2];

    fifo_rd_streamer #(.DATA_WIDTH(8), .RD_LATENCY(1), .CNT_WIDTH(32)) u_dut0 (
        .rd_clk(clk), .rd_rst(rst_a[0]), .bus(bus0.master), .word_cnt(wc0), .underflow(uf[0]));
    fifo_rd_streamer #(.DATA_WIDTH(8), .RD_LATENCY(2), .CNT_WIDTH(32)) u_dut1 (
        .rd_clk(clk), .rd_rst(rst_a[1]), .bus(bus1.master), .word_cnt(wc1), .underflow(uf[1]));
    fifo_rd_streamer #(.DATA_WIDTH(8), .RD_LATENCY(3), .CNT_WIDTH(4)) u_dut2 (
        .rd_clk(clk), .rd_rst(rst_a[2]), .bus(bus2.master), .word_cnt(wc2), .underflow(uf[2]));

    // Observed outputs for the current cycle
    logic        o_rd_en [NL];
    logic        o_valid [NL];
    logic [7:0]  o_data  [NL];
    logic [31:0] o_wc    [NL];
    logic        o_uf    [NL];

    // Reference model: FIFO contents, read-order scoreboard, read pipeline
    int          lat   [NL] = '{1, 2, 3};
    logic [7:0]  fifo_q [NL][$];
    logic [7:0]  exp_q  [NL][$];
    logic [7:0]  pipe_d [NL][4];
    int          outstanding [NL];
    int          delivered   [NL];
    int unsigned cnt         [NL];
    int          ready_mode  [NL];
    bit          empty_toggle[NL];
    int          cyc;
    int          checks;
    int          failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int l);
        return (l == 2) ? (cnt[l] & 32'hF) : cnt[l];
    endfunction

    task automatic drive_observe();
        logic [7:0] v;
        for (int l = 0; l < NL; l++) begin
            rdd_a[l]   = pipe_d[l][lat[l]-1];
            empty_a[l] = (fifo_q[l].size() == 0) || (empty_toggle[l] && (cyc % 2 == 1));
            case (ready_mode[l])
                0:       ready_a[l] = 1'b0;
                1:       ready_a[l] = 1'b1;
                default: ready_a[l] = ($urandom_range(0, 1) == 1);
            endcase
        end
        #1;
        o_rd_en[0] = bus0.rd_en; o_valid[0] = bus0.m_valid; o_data[0] = bus0.m_data;
        o_wc[0] = wc0; o_uf[0] = uf[0];
        o_rd_en[1] = bus1.rd_en; o_valid[1] = bus1.m_valid; o_data[1] = bus1.m_data;
        o_wc[1] = wc1; o_uf[1] = uf[1];
        o_rd_en[2] = bus2.rd_en; o_valid[2] = bus2.m_valid; o_data[2] = bus2.m_data;
        o_wc[2] = {28'd0, wc2}; o_uf[2] = uf[2];
        for (int l = 0; l < NL; l++) begin
            if (rst_a[l]) begin
                chk("rd_en_in_reset", {31'd0, o_rd_en[l]}, 32'd0);
                exp_q[l].delete();
                outstanding[l] = 0;
                cnt[l] = 0;
            end else begin
                chk("word_cnt", o_wc[l], cnt_exp(l));
                chk("underflow", {31'd0, o_uf[l]}, 32'd0);
                chk("rd_en_while_empty", {31'd0, o_rd_en[l] & empty_a[l]}, 32'd0);
                for (int k = 3; k > 0; k--) pipe_d[l][k] = pipe_d[l][k-1];
                pipe_d[l][0] = 8'h00;
                if (o_rd_en[l] === 1'b1 && !empty_a[l]) begin
                    v = fifo_q[l].pop_front();
                    exp_q[l].push_back(v);
                    pipe_d[l][0] = v;
                    outstanding[l]++;
                end
                if (o_valid[l] === 1'b1 && ready_a[l]) begin
                    if (exp_q[l].size() == 0) begin
                        chk("valid_without_word", {31'd0, o_valid[l]}, 32'd0);
                    end else begin
                        chk("out_data", {24'd0, o_data[l]}, {24'd0, exp_q[l].pop_front()});
                    end
                    outstanding[l]--;
                    cnt[l]++;
                    delivered[l]++;
                end
                chk("credit_limit", outstanding[l], (outstanding[l] <= lat[l] + 1) ? outstanding[l] : lat[l] + 1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_idle(input int l, input int limit);
        int g;
        g = 0;
        while ((fifo_q[l].size() != 0 || exp_q[l].size() != 0) && g < limit) begin
            drive_observe();
            tick();
            g++;
        end
        chk("drain_timeout", g, (g < limit) ? g : limit - 1);
    endtask

    initial begin
        vec_t tv [7];
        int   pulses, d0, g;
        int   fed [NL];
        int   start [NL];
        bit   busy;

        tv[0] = '{1, 1, 0, 1, 8'h00};
        tv[1] = '{1, 1, 0, 1, 8'h00};
        tv[2] = '{1, 1, 1, 1, 8'h11};
        tv[3] = '{1, 1, 1, 1, 8'h12};
        tv[4] = '{1, 0, 1, 1, 8'h13};
        tv[5] = '{1, 0, 1, 1, 8'h14};
        tv[6] = '{1, 0, 0, 0, 8'h00};

        checks = 0; failures = 0; cyc = 0;
        for (int l = 0; l < NL; l++) begin
            rst_a[l] = 1'b1; empty_a[l] = 1'b1; ready_a[l] = 1'b0; rdd_a[l] = 8'h00;
            outstanding[l] = 0; delivered[l] = 0; cnt[l] = 0;
            ready_mode[l] = 1; empty_toggle[l] = 1'b0;
            for (int k = 0; k < 4; k++) pipe_d[l][k] = 8'h00;
        end

        // Reset, including a reset cycle with a non-empty FIFO
        @(negedge clk);
        drive_observe();
        tick();
        for (int i = 0; i < 4; i++) fifo_q[0].push_back(8'h11 + 8'(i));
        drive_observe();
        for (int l = 0; l < NL; l++) begin
            chk("rst_m_valid", {31'd0, o_valid[l]}, 32'd0);
            chk("rst_m_data", {24'd0, o_data[l]}, 32'd0);
            chk("rst_word_cnt", o_wc[l], 32'd0);
            chk("rst_underflow", {31'd0, o_uf[l]}, 32'd0);
        end
        tick();
        for (int l = 0; l < NL; l++) rst_a[l] = 1'b0;

        // Four-word preload, latency 1, cycle-exact table
        for (int i = 0; i < 7; i++) begin
            ready_mode[0] = tv[i].ready ? 1 : 0;
            drive_observe();
            chk("tbl_rd_en", {31'd0, o_rd_en[0]}, {31'd0, tv[i].exp_rd_en});
            chk("tbl_m_valid", {31'd0, o_valid[0]}, {31'd0, tv[i].exp_valid});
            if (tv[i].chk_data) chk("tbl_m_data", {24'd0, o_data[0]}, {24'd0, tv[i].exp_data});
            tick();
        end
        chk("tbl_word_cnt", o_wc[0], 32'd4);

        // Backpressure: exactly DEPTH reads, head held, then gapless drain
        ready_mode[0] = 0;
        for (int i = 0; i < 8; i++) fifo_q[0].push_back(8'h20 + 8'(i));
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive_observe();
            if (o_rd_en[0] === 1'b1) pulses++;
            if (i >= 3) chk("hold_m_data", {24'd0, o_data[0]}, 32'h20);
            tick();
        end
        chk("hold_rd_en_pulses", pulses, 2);
        chk("hold_m_valid", {31'd0, o_valid[0]}, 32'd1);
        ready_mode[0] = 1;
        for (int i = 0; i < 8; i++) begin
            drive_observe();
            chk("drain_no_gap", {31'd0, o_valid[0]}, 32'd1);
            tick();
        end
        run_until_idle(0, 20);

        // empty toggling every cycle
        empty_toggle[0] = 1'b1;
        d0 = delivered[0];
        for (int i = 0; i < 20; i++) fifo_q[0].push_back(8'h60 + 8'(i));
        run_until_idle(0, 200);
        chk("toggle_words_delivered", delivered[0] - d0, 20);
        empty_toggle[0] = 1'b0;

        // Random backpressure and supply on all three latencies
        for (int l = 0; l < NL; l++) begin
            ready_mode[l] = 2; fed[l] = 0; start[l] = delivered[l];
        end
        g = 0;
        busy = 1'b1;
        while (busy && g < 30000) begin
            for (int l = 0; l < NL; l++) begin
                if (fed[l] < N_RAND && $urandom_range(0, 9) < 6) begin
                    fifo_q[l].push_back(8'($urandom_range(0, 255)));
                    fed[l]++;
                end
            end
            drive_observe();
            tick();
            g++;
            busy = 1'b0;
            for (int l = 0; l < NL; l++) if (delivered[l] - start[l] < N_RAND) busy = 1'b1;
        end
        for (int l = 0; l < NL; l++) chk("rand_words_delivered", delivered[l] - start[l], N_RAND);

        // Mid-operation reset on latency 2: two words buffered, one in flight
        ready_mode[1] = 1;
        run_until_idle(1, 50);
        ready_mode[1] = 0;
        for (int i = 0; i < 6; i++) fifo_q[1].push_back(8'h41 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            drive_observe();
            tick();
        end
        chk("rstmid_outstanding", outstanding[1], 3);
        rst_a[1] = 1'b1;
        drive_observe();
        tick();
        rst_a[1] = 1'b0;
        drive_observe();
        chk("rstmid_m_valid", {31'd0, o_valid[1]}, 32'd0);
        chk("rstmid_word_cnt", o_wc[1], 32'd0);
        tick();
        ready_mode[1] = 1;
        d0 = delivered[1];
        run_until_idle(1, 50);
        chk("rstmid_words_after", delivered[1] - d0, 3);

        // Counter wrap with a 4-bit counter
        ready_mode[2] = 1;
        run_until_idle(2, 50);
        rst_a[2] = 1'b1;
        drive_observe();
        tick();
        rst_a[2] = 1'b0;
        for (int i = 0; i < 17; i++) fifo_q[2].push_back(8'h80 + 8'(i));
        run_until_idle(2, 100);
        drive_observe();
        chk("wrap_word_cnt", o_wc[2], 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
